// File: rtl/console_tx_pkg.sv
// Shared frame constants and serialiser state encoding for the console UART sink.
package console_tx_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/console_tx_byte_fifo.sv
// Byte FIFO with extra-MSB pointers; full/empty are registered from next-state pointers.
// Pushes into a full FIFO and pops from an empty one are ignored.
module byte_fifo
  import console_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              full_q, empty_q;
  logic              do_push, do_pop;

  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= (wr_ptr_d ^ rd_ptr_d) == {1'b1, {AW{1'b0}}};
      empty_q  <= wr_ptr_d == rd_ptr_d;
    end
  end

  // Storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/console_tx.sv
// Console output sink: buffers writeback byte strobes and serialises them as 8N1 UART frames.
// Define CONSOLE_TX_PARITY_EN to add an even parity bit between data bit 7 and the stop bit.
module console_tx
  import console_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              busy,
  output logic              tx,
  output logic [15:0]       dropped
);

  localparam int              BW       = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]   BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  tx_state_e         state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [15:0]       dropped_q, dropped_d;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              push, pop, bit_end, stop_done;
`ifdef CONSOLE_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign push      = wr_en & ~full;
  assign bit_end   = baud_q == BAUD_MAX;
  assign stop_done = (state_q == ST_STOP) & bit_end;
  // Popping on the STOP-completion edge keeps back-to-back frames gapless.
  assign pop       = ~fifo_empty & ((state_q == ST_IDLE) | stop_done);

  byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (wr_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef CONSOLE_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != ST_IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;
    case (state_q)
      ST_IDLE: ;
      ST_START: if (bit_end) begin
        state_d = ST_DATA;
        bit_d   = 3'd0;
      end
      ST_DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
`ifdef CONSOLE_TX_PARITY_EN
        if (bit_q == 3'd7) state_d = ST_PARITY;
`else
        if (bit_q == 3'd7) state_d = ST_STOP;
`endif
      end
`ifdef CONSOLE_TX_PARITY_EN
      ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
      ST_STOP: if (bit_end) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      state_d = ST_START;
      baud_d  = '0;
      shift_d = fifo_dout;
`ifdef CONSOLE_TX_PARITY_EN
      par_d   = ^fifo_dout;
`endif
    end
  end

  // The line is driven from a flop so it never glitches between bits.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef CONSOLE_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_comb begin
    dropped_d = dropped_q;
    if (wr_en && full && (dropped_q != 16'hFFFF)) dropped_d = dropped_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      dropped_q <= '0;
`ifdef CONSOLE_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      dropped_q <= dropped_d;
`ifdef CONSOLE_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign busy    = ~fifo_empty | (state_q != ST_IDLE);
  assign dropped = dropped_q;

endmodule

// File: tb/tb_console_tx.sv
// Self-checking bench for console_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_console_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef CONSOLE_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR   = 1'b0;
`endif
  localparam int FRAME = NBITS * CPB;
  localparam int MAXC  = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        full, busy, tx;
  logic [15:0] dropped;

  always #5 clk = ~clk;

  console_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .busy    (busy),
    .tx      (tx),
    .dropped (dropped)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a byte queue plus a per-cycle expected line waveform.
  logic       exp_tx [MAXC];
  logic [7:0] q [$];
  int         free_edge = 0;
  int         exp_drop  = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       par;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (PAR && i == 9) return ^d;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    q.delete();
    free_edge = 0;
    exp_drop  = 0;
    for (int c = cyc; c < MAXC; c++) exp_tx[c] = 1'b1;
  endfunction

  function automatic void model_edge(input logic we, input logic [7:0] d);
    bit full_before;
    logic [7:0] b;
    cyc++;
    full_before = (q.size() == DEPTH);
    if (cyc >= free_edge && q.size() > 0) begin
      b = q.pop_front();
      for (int i = 0; i < NBITS; i++)
        for (int j = 0; j < CPB; j++)
          if (cyc + i*CPB + j < MAXC) exp_tx[cyc + i*CPB + j] = frame_bit(b, i);
      free_edge = cyc + FRAME;
    end
    if (we) begin
      if (full_before) begin
        if (exp_drop < 65535) exp_drop++;
      end else begin
        q.push_back(d);
      end
    end
  endfunction

  task automatic step(input logic we, input logic [7:0] d);
    wr_en   = we;
    wr_data = d;
    @(posedge clk);
    model_edge(we, d);
    @(negedge clk);
    wr_en = 1'b0;
    chk("tx", {31'd0, tx}, {31'd0, exp_tx[cyc]});
    chk("busy", {31'd0, busy}, {31'd0, (q.size() > 0) || (cyc < free_edge)});
    chk("full", {31'd0, full}, {31'd0, q.size() == DEPTH});
    chk("dropped", {16'd0, dropped}, exp_drop);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    int n0, rel;
    logic eb;
    for (int c = 0; c < MAXC; c++) exp_tx[c] = 1'b1;
    tbl[0] = '{d: 8'h41, par: 1'b0};
    tbl[1] = '{d: 8'h07, par: 1'b1};
    tbl[2] = '{d: 8'h55, par: 1'b0};
    tbl[3] = '{d: 8'hAA, par: 1'b0};
    tbl[4] = '{d: 8'h80, par: 1'b1};
    tbl[5] = '{d: 8'hFF, par: 1'b0};
    tbl[6] = '{d: 8'h00, par: 1'b0};
    tbl[7] = '{d: 8'h0E, par: 1'b1};

    // Reset state
    #12;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_dropped", {16'd0, dropped}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 8'h00);

    // Single-byte frames, bit values checked mid-bit against the table
    for (int k = 0; k < 8; k++) begin
      step(1'b1, tbl[k].d);
      n0 = cyc;
      for (int t = 0; t < FRAME + 2; t++) begin
        step(1'b0, 8'h00);
        rel = cyc - (n0 + 1);
        if (rel >= 0 && rel < FRAME && (rel % CPB) == CPB/2) begin
          if (rel / CPB == 0) eb = 1'b0;
          else if (rel / CPB <= 8) eb = tbl[k].d[rel/CPB - 1];
          else if (PAR && rel / CPB == 9) eb = tbl[k].par;
          else eb = 1'b1;
          chk("tbl_bit", {31'd0, tx}, {31'd0, eb});
        end
        if (cyc == n0 + 1) chk("tbl_latency", {31'd0, tx}, 32'd0);
        if (cyc == n0 + FRAME) chk("tbl_busy_hold", {31'd0, busy}, 32'd1);
        if (cyc == n0 + FRAME + 1) chk("tbl_busy_fall", {31'd0, busy}, 32'd0);
      end
    end

    // Back-to-back frames: second start bit exactly one frame after the first
    step(1'b1, 8'h55);
    n0 = cyc;
    step(1'b1, 8'hAA);
    for (int t = 0; t < 2*FRAME + 3; t++) begin
      step(1'b0, 8'h00);
      if (cyc == n0 + FRAME) chk("b2b_stop1", {31'd0, tx}, 32'd1);
      if (cyc == n0 + FRAME) chk("b2b_busy", {31'd0, busy}, 32'd1);
      if (cyc == n0 + FRAME + 1) chk("b2b_start2", {31'd0, tx}, 32'd0);
    end

    // Overflow: six writes, five accepted, then a write on the full+pop edge
    n0 = cyc + 1;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 8'h30 + 8'(k));
      if (k == 4) chk("ovf_full", {31'd0, full}, 32'd1);
    end
    chk("ovf_dropped", {16'd0, dropped}, 32'd1);
    while (cyc < n0 + FRAME) step(1'b0, 8'h00);
    step(1'b1, 8'hEE);
    chk("fullpop_dropped", {16'd0, dropped}, 32'd2);
    chk("fullpop_full", {31'd0, full}, 32'd0);
    repeat (5*FRAME + 5) step(1'b0, 8'h00);

    // Reset during data bit 3 of 0x0F
    step(1'b1, 8'h0F);
    n0 = cyc;
    while (cyc < n0 + 1 + 4*CPB + 1) step(1'b0, 8'h00);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_dropped", {16'd0, dropped}, 32'd0);
    chk("midrst_full", {31'd0, full}, 32'd0);
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) step(1'b0, 8'h00);
    step(1'b1, 8'h5A);
    repeat (FRAME + 3) step(1'b0, 8'h00);

    // Randomised traffic against the reference model
    repeat (2500) step($urandom_range(0, 11) == 0, 8'($urandom));
    repeat ((DEPTH + 1) * FRAME + 5) step(1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/console_tx.md
# console_tx

Console output sink for the CPU. The pipeline's writeback stage presents each byte that targets register 0 as a one-cycle write strobe. This block buffers those bytes in a FIFO and serialises them onto a single UART line, 8 data bits, LSB first, one stop bit. The CPU cannot stall on console output, so bytes that arrive when the FIFO is full are dropped and counted.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clock cycles per serial bit; minimum 2.
- FIFO_DEPTH, default 16: FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1: single clock; all state updates on posedge.
- rst_n  in  1: asynchronous, active-low reset.
- wr_en  in  1: byte strobe from writeback (register-0 write, not bad).
- wr_data  in  8: byte to send; the low byte of the writeback value.
- full  out  1: FIFO holds FIFO_DEPTH entries.
- busy  out  1: FIFO not empty, or the serialiser is not IDLE.
- tx  out  1: serial line; idles high.
- dropped  out  16: count of bytes rejected because the FIFO was full; saturates at 0xFFFF.

## Operation
FIFO:
- Read and write pointers are log2(FIFO_DEPTH)+1 bits wide. The MSB distinguishes full from empty.
- A write is accepted when wr_en is high and full is low.
- If wr_en is high and full is high, the byte is discarded and dropped increments. This applies even if a pop happens in the same cycle.
- A pop happens when the serialiser is in IDLE and the FIFO is not empty.
- A simultaneous push and pop on a non-full FIFO is legal; the occupancy is unchanged.
- A write into an empty FIFO is not visible to the serialiser until the following cycle. There is no bypass.

Serialiser FSM, with states IDLE, START, DATA, PARITY (compiled in only with the macro), STOP:
- **IDLE**: tx=1. On a pop, load the shift register with the head byte, clear the baud counter, and go to START.
- **START**: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- **DATA**: tx=shift[0] for CLKS_PER_BIT cycles. At the end of each bit, shift right and increment the bit index. After bit index 7, go to PARITY if enabled, otherwise STOP.
- **PARITY**: tx=even parity of the byte (XOR of its 8 bits) for CLKS_PER_BIT cycles, then go to STOP.
- **STOP**: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- In IDLE, a pop can occur on the same edge that STOP completes. Back-to-back frames therefore have no extra idle cycle.

Counters:
- The baud counter counts 0..CLKS_PER_BIT-1, using $clog2(CLKS_PER_BIT) bits, and wraps to 0 at each bit boundary.
- The bit index is 3 bits.

## Timing
- Reset values: tx=1, full=0, busy=0, dropped=0, FSM=IDLE, pointers=0. FIFO contents are not reset.
- Reset asserted mid-frame forces tx=1 immediately (asynchronous). The in-flight frame and all buffered bytes are lost, and dropped is cleared.
- Latency, FIFO empty and IDLE:
  - wr_en sampled high at edge N.
  - Pop at edge N+1.
  - tx falls after edge N+1.
- Frame length is 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity.
- full and busy are registered and change only after a clock edge.

## Configuration
- CONSOLE_TX_PARITY_EN defined: the PARITY state exists and every frame carries an even parity bit between data bit 7 and the stop bit (11 bits total).
- CONSOLE_TX_PARITY_EN undefined: the PARITY state and its logic are absent; frames are 10 bits.

## Structure
- Frame constants go in macros.v alongside the pipeline macros:
  - state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3 bits);
  - data width 8.
- Sub-module byte_fifo holds the FIFO. It has ports clk, rst_n, push, din, pop, dout, full, empty. It is parameterised by FIFO_DEPTH.
- console_tx instantiates byte_fifo and contains the FSM, the baud counter and the dropped counter.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.

- **Single byte**: write 0x41 at edge N.
  - tx is low from N+1 for 4 cycles, then 1,0,0,0,0,0,1,0 at 4 cycles each, then high for 4 cycles.
  - busy falls at N+41.
- **Back-to-back**: write 0x55 then 0xAA on consecutive cycles.
  - The second start bit begins exactly 40 cycles after the first, with no idle gap.
- **Overflow**: write 6 bytes on consecutive cycles starting from an empty, idle FIFO.
  - 5 are accepted: 1 popped plus 4 buffered.
  - dropped=1; full is high for the cycle after the 5th write.
  - tx emits the first 5 bytes in order.
- **Full with simultaneous pop**: with the FIFO full, assert wr_en on the same edge as a pop.
  - The byte is dropped and dropped increments.
- **Reset mid-frame**: deassert rst_n during data bit 3 of 0x0F.
  - tx=1 and busy=0 immediately.
  - After release, the line stays idle until a new write.
- **Parity**, with CONSOLE_TX_PARITY_EN defined:
  - 0x41 gives parity bit 0; 0x07 gives parity bit 1.
  - Frame length is 44 cycles.
